stream_checker: RTL and testbench
=================================

// Module: stream_checker
// PURPOSE
//  Self-checking valid/ready sink: the reader end of the up_/down_ stream used by fifo.
//  - Consumes N_CHECKS words from an upstream source (e.g. fifo down_* side).
//  - Applies pseudo-random backpressure.
//  - Compares each accepted word with an incrementing reference sequence.
//  - Reports done, error flag and counts, for on-chip FIFO/link soak tests.
// PARAMETERS
//  W_DATA    8     data width of up_data / seed
//  N_CHECKS  1000  words to accept before done
//  W_STALL   3     stall field width; each stall is 0..2^W_STALL-1 cycles
//  W_CNT     16    width of rx_cnt / err_cnt (must hold N_CHECKS)
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst         in   1        async reset, active-high
//  start       in   1        1-cycle pulse: begin a run (honoured in IDLE/DONE only)
//  seed        in   W_DATA   first expected word, sampled on accepted start
//  up_data     in   W_DATA   stream data
//  up_valid    in   1        stream valid
//  up_ready    out  1        stream ready, registered
//  busy        out  1        1 in WAIT/RECV
//  done        out  1        1 in DONE
//  err         out  1        sticky mismatch flag for current run
//  rx_cnt      out  W_CNT    words accepted this run
//  err_cnt     out  W_CNT    mismatches this run, saturating at all-ones
//  first_bad   out  W_DATA   up_data of first mismatch (0 if none)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; up_ready, busy, done, err, rx_cnt, err_cnt, first_bad = 0;
//    expected=0; LFSR=16'hACE1. Reset mid-run aborts; no word is accepted during rst.
//  - Transfer: occurs at posedge when up_valid & up_ready.
//    - up_data is compared with expected in that cycle.
//    - expected <= expected+1 (mod 2^W_DATA); rx_cnt++.
//  - Handshake rules:
//    - up_ready is never a function of up_valid.
//    - Once up_ready=1, it holds until a transfer occurs.
//    - Source-side valid/ready rules are the source's responsibility; not checked here.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; steps every cycle out of reset.
//    Stall load value = lfsr[W_STALL-1:0] at load time.
//  - FSM:
//    - IDLE: on start -> expected<=seed, counters/err/first_bad cleared, load stall; -> WAIT (stall>0) or RECV (stall=0).
//    - WAIT: up_ready=0; stall counter decrements; at 1 -> RECV (ready asserts next cycle).
//    - RECV: up_ready=1.
//      - On transfer with rx_cnt+1==N_CHECKS -> DONE, ready<=0.
//      - Else reload stall: 0 stays in RECV (back-to-back, ready stays 1); >0 -> WAIT, ready<=0.
//    - DONE: outputs hold. start -> same as from IDLE (new run).
//  - start while busy is ignored. seed is ignored except on an accepted start.
//  - Mismatch (up_data!==expected at transfer):
//    - err<=1; err_cnt++ (saturating).
//    - first_bad captured only if err was 0.
//    - Checking continues; a mismatch does not resync expected.
//  - Throughput: 1 word/cycle max in RECV with stall=0; latency start->first possible ready = 1 cycle.
// CONFIGURATION
//  STREAM_CHECKER_BACKPRESSURE_EN:
//    defined   -> pseudo-random stalls as above.
//    undefined -> stall forced to 0: start goes straight to RECV; up_ready=1 for the whole run;
//                 WAIT never entered; LFSR may be omitted.
// TESTING
//  1. Reset: rst=1 mid-RECV with up_valid=1 -> within same cycle up_ready=0, all outputs 0, state IDLE.
//  2. Clean run: N_CHECKS=1000, seed=8'hF0, source sends F0,F1,...,FF,00,... with random valid gaps
//     -> done=1, rx_cnt=1000, err=0, err_cnt=0, wrap FF->00 accepted.
//  3. Single fault: same run, word #5 corrupted to 8'h00 (expected F5)
//     -> err=1, err_cnt=1, first_bad=8'h00; word #6 (F6) still passes.
//  4. Backpressure: BACKPRESSURE_EN on, source valid held 1
//     -> up_ready low-cycles match the model LFSR stall sequence from 16'hACE1;
//        data never lost or duplicated (rx_cnt == source accept count).
//  5. Start handling: start pulse while busy -> ignored, rx_cnt continues;
//     start in DONE with seed=8'h10 -> counters clear, first expected 8'h10.
//  6. Saturation: W_CNT=4, all 20 words bad -> err_cnt stops at 4'hF; first_bad = first word.

Source files
------------

// File: rtl/stream_checker_if.sv
// stream_checker_if: valid/ready word stream.
//   data  : W_DATA-bit payload, driven by the source
//   valid : source has a word on data
//   ready : sink will take the word at the next posedge
// A transfer happens on a posedge where valid & ready are both high.
interface stream_checker_if #(
    parameter int W_DATA = 8
) ();
    logic [W_DATA-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_checker.sv
// stream_checker: self-checking valid/ready sink for FIFO/link soak tests.
// Accepts N_CHECKS words, compares each with an incrementing sequence that
// starts at seed, and reports done/err/counts.
// Optional feature macro: STREAM_CHECKER_BACKPRESSURE_EN
//   defined   -> pseudo-random stalls from a 16-bit Galois LFSR
//   undefined -> no stalls, ready stays high for the whole run
// Ports:
//   clk, rst      clock, async active-high reset
//   start, seed   run start pulse (IDLE/DONE only) and first expected word
//   up            stream slave (data, valid in; ready out, registered)
//   busy, done    run in progress / run complete
//   err           sticky mismatch flag for the current run
//   rx_cnt        words accepted this run
//   err_cnt       mismatches this run, saturating
//   first_bad     data of the first mismatching word (0 if none)
//
// state | meaning
// IDLE  | after reset, waiting for start
// WAIT  | stalling, ready low, stall counter running
// RECV  | ready high, waiting for a transfer
// DONE  | N_CHECKS words accepted, outputs held until next start
module stream_checker #(
    parameter int W_DATA   = 8,
    parameter int N_CHECKS = 1000,
    parameter int W_STALL  = 3,
    parameter int W_CNT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_DATA-1:0]   seed,
    stream_checker_if.slave     up,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [W_CNT-1:0]    rx_cnt,
    output logic [W_CNT-1:0]    err_cnt,
    output logic [W_DATA-1:0]   first_bad
);
    // run_q counts accepted words independently of rx_cnt so that a narrow
    // W_CNT still ends the run at exactly N_CHECKS words.
    localparam int W_RUN = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;
    localparam logic [W_RUN-1:0] LAST = W_RUN'(N_CHECKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RECV, DONE} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [W_STALL-1:0]  stall_q, stall_d, stall_ld;
    logic [W_DATA-1:0]   exp_q, exp_d;
    logic [W_RUN-1:0]    run_q, run_d;
    logic [W_CNT-1:0]    rx_q, rx_d;
    logic [W_CNT-1:0]    errc_q, errc_d;
    logic                err_q, err_d;
    logic [W_DATA-1:0]   fbad_q, fbad_d;
    logic                xfer;

`ifdef STREAM_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Galois form of x^16+x^14+x^13+x^11+1, free-running out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign stall_ld = lfsr_q[W_STALL-1:0];
`else
    assign stall_ld = '0;
`endif

    assign xfer = up.valid & ready_q;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        stall_d = stall_q;
        exp_d   = exp_q;
        run_d   = run_q;
        rx_d    = rx_q;
        errc_d  = errc_q;
        err_d   = err_q;
        fbad_d  = fbad_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    exp_d  = seed;
                    run_d  = '0;
                    rx_d   = '0;
                    errc_d = '0;
                    err_d  = 1'b0;
                    fbad_d = '0;
                    if (stall_ld == '0) begin
                        state_d = RECV;
                        ready_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        stall_d = stall_ld;
                        ready_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                // ready is raised on the last stall cycle so it is high next cycle
                if (stall_q <= W_STALL'(1)) begin
                    state_d = RECV;
                    ready_d = 1'b1;
                end else begin
                    stall_d = stall_q - 1'b1;
                end
            end
            RECV: begin
                if (xfer) begin
                    exp_d = exp_q + 1'b1;
                    run_d = run_q + 1'b1;
                    rx_d  = rx_q + 1'b1;
                    if (up.data != exp_q) begin
                        err_d = 1'b1;
                        if (errc_q != '1) errc_d = errc_q + 1'b1;
                        if (!err_q)       fbad_d = up.data;
                    end
                    if (run_q == LAST) begin
                        state_d = DONE;
                        ready_d = 1'b0;
                    end else if (stall_ld == '0) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        stall_d = stall_ld;
                        ready_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            stall_q <= '0;
            exp_q   <= '0;
            run_q   <= '0;
            rx_q    <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            fbad_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            rx_q    <= rx_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
            fbad_q  <= fbad_d;
        end
    end

    assign up.ready  = ready_q;
    assign busy      = (state_q == WAIT) || (state_q == RECV);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rx_cnt    = rx_q;
    assign err_cnt   = errc_q;
    assign first_bad = fbad_q;
endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: a 1000-word instance and a 20-word instance with
// a 4-bit counter for the saturation case. Stimulus pushes expected results
// into queues; monitors pop them on every observed transfer.
module tb_stream_checker;
    localparam int N  = 1000;
    localparam int NS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    logic [7:0] seed = 8'h00, seed2 = 8'h00;

    always #5 clk = ~clk;

    stream_checker_if #(.W_DATA(8)) up  ();
    stream_checker_if #(.W_DATA(8)) up2 ();

    logic        busy, done, err;
    logic [15:0] rx_cnt, err_cnt;
    logic [7:0]  first_bad;
    logic        busy2, done2, err2;
    logic [3:0]  rx_cnt2, err_cnt2;
    logic [7:0]  first_bad2;

    stream_checker #(.W_DATA(8), .N_CHECKS(N), .W_STALL(3), .W_CNT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .up(up),
        .busy(busy), .done(done), .err(err), .rx_cnt(rx_cnt),
        .err_cnt(err_cnt), .first_bad(first_bad)
    );

    stream_checker #(.W_DATA(8), .N_CHECKS(NS), .W_STALL(3), .W_CNT(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .seed(seed2), .up(up2),
        .busy(busy2), .done(done2), .err(err2), .rx_cnt(rx_cnt2),
        .err_cnt(err_cnt2), .first_bad(first_bad2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] rx;
        logic        e;
        logic [15:0] ec;
        logic [7:0]  fb;
        bit          last;
    } exp_t;

    exp_t exp_q  [$];
    exp_t exp2_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not happen as required (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"},     up.ready,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_err"},       err,       0);
        chk({tag, "_rx_cnt"},    rx_cnt,    0);
        chk({tag, "_err_cnt"},   err_cnt,   0);
        chk({tag, "_first_bad"}, first_bad, 0);
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin up2.valid = v; up2.data = d; end
        else     begin up.valid  = v; up.data  = d; end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? up2.ready : up.ready;
    endfunction

    task automatic pulse_start(input bit sel, input logic [7:0] s);
        if (sel) begin start2 = 1'b1; seed2 = s; end
        else     begin start  = 1'b1; seed  = s; end
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        seed   = 8'($urandom);
        seed2  = 8'($urandom);
    endtask

    // Offers one word and holds it until accepted; called at posedge+1.
    task automatic send(input bit sel, input logic [7:0] d, input bit gaps, output bit ok);
        int g;
        int n;
        ok = 1'b1;
        g  = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            drive(sel, 1'b0, 8'($urandom));
            @(posedge clk); #1;
        end
        drive(sel, 1'b1, d);
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy(sel)) break;
            n++;
            if (n > 64) begin
                fail_now("ready_timeout");
                drive(sel, 1'b0, 8'h00);
                ok = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'($urandom));
    endtask

    // Reference: word i must equal seed+i mod 256; err/err_cnt/first_bad follow.
    task automatic run(input logic [7:0] s, input int n_send, input int bad_idx,
                       input int busy_idx, input bit gaps);
        logic        e;
        logic [15:0] ec;
        logic [7:0]  fb;
        logic [7:0]  want;
        logic [7:0]  d;
        logic [7:0]  w [$];
        exp_t        ent;
        bit          ok;
        e = 1'b0; ec = 16'h0; fb = 8'h00;
        for (int i = 0; i < n_send; i++) begin
            want = s + 8'(i);
            d    = (i == bad_idx) ? 8'h00 : want;
            w.push_back(d);
            if (d !== want) begin
                if (!e) fb = d;
                e = 1'b1;
                if (ec != 16'hFFFF) ec = ec + 16'h1;
            end
            ent.rx = 16'(i + 1); ent.e = e; ent.ec = ec; ent.fb = fb;
            ent.last = (i == N - 1);
            exp_q.push_back(ent);
        end
        pulse_start(1'b0, s);
        for (int i = 0; i < n_send; i++) begin
            if (i == busy_idx) pulse_start(1'b0, 8'($urandom));
            send(1'b0, w[i], gaps, ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 32) begin
                fail_now({tag, "_done_timeout"});
                break;
            end
        end
        @(posedge clk); #1;
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Main monitor: scoreboard pops, LFSR stall model, handshake rules.
    initial begin : mon
        logic [15:0] lf;
        bit   active, prev_ok, p_xfer, p_start, p_ready, gap_on;
        int   low, want_gap, load;
        exp_t e;
        lf = 16'hACE1; active = 0; prev_ok = 0; p_xfer = 0; p_start = 0;
        p_ready = 0; gap_on = 0; low = 0; want_gap = 0; load = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lf = 16'hACE1; active = 0; prev_ok = 0; gap_on = 0;
                p_xfer = 0; p_start = 0; p_ready = 0;
                exp_q.delete();
            end else begin
                if (prev_ok) begin
`ifdef STREAM_CHECKER_BACKPRESSURE_EN
                    load = int'(lf[2:0]);
`else
                    load = 0;
`endif
                    if (p_start) begin
                        active = 1;
                        chk("start_rx_clr",   rx_cnt,    0);
                        chk("start_ec_clr",   err_cnt,   0);
                        chk("start_err_clr",  err,       0);
                        chk("start_fb_clr",   first_bad, 0);
                        chk("start_busy",     busy,      1);
                        chk("start_done_clr", done,      0);
                        gap_on = 1; low = 0; want_gap = load;
                    end
                    if (p_xfer) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_transfer");
                        end else begin
                            e = exp_q.pop_front();
                            chk("rx_cnt",    rx_cnt,    e.rx);
                            chk("err",       err,       e.e);
                            chk("err_cnt",   err_cnt,   e.ec);
                            chk("first_bad", first_bad, e.fb);
                            if (e.last) begin
                                active = 0; gap_on = 0;
                                chk("done_set",   done, 1);
                                chk("busy_clear", busy, 0);
                            end else begin
                                gap_on = 1; low = 0; want_gap = load;
                            end
                        end
                    end
                    if (p_ready && !p_xfer) chk("ready_hold", up.ready, 1);
                    lf = lstep(lf);
                end
                if (gap_on) begin
                    if (!up.ready) begin
                        low++;
                        if (low > 16) begin
                            chk("stall_len", low, want_gap);
                            gap_on = 0;
                        end
                    end else begin
                        chk("stall_len", low, want_gap);
                        gap_on = 0;
                    end
                end
                if (!active) chk("idle_ready", up.ready, 0);
                p_xfer  = up.valid && up.ready;
                p_start = start && !active;
                p_ready = up.ready;
                prev_ok = 1;
            end
        end
    end

    // Saturation monitor for the narrow-counter instance.
    initial begin : mon_sat
        bit   p;
        exp_t e;
        p = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p = 0;
            end else begin
                if (p) begin
                    if (exp2_q.size() == 0) begin
                        fail_now("sat_unexpected_transfer");
                    end else begin
                        e = exp2_q.pop_front();
                        chk("sat_rx_cnt",    rx_cnt2,    e.rx);
                        chk("sat_err_cnt",   err_cnt2,   e.ec);
                        chk("sat_first_bad", first_bad2, e.fb);
                        chk("sat_err",       err2,       e.e);
                        if (e.last) chk("sat_done", done2, 1);
                    end
                end
                p = up2.valid && up2.ready;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t ent;
        bit   ok;
        int   n;
        up.valid = 1'b0; up.data = 8'h00;
        up2.valid = 1'b0; up2.data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a run while a word is offered
        run(8'h5A, 3, -1, -1, 1'b1);
        up.valid = 1'b1; up.data = 8'h5D;
        n = 0;
        forever begin
            @(negedge clk);
            if (up.ready) break;
            n++;
            if (n > 64) begin fail_now("mid_reset_ready_timeout"); break; end
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(posedge clk); #1;
        up.valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // clean run from F0, wraps FF->00
        run(8'hF0, N, -1, -1, 1'b1);
        wait_done("clean");
        chk("clean_err", err, 0);
        chk("clean_rx",  rx_cnt, N);

        // word 5 corrupted, start pulse mid-run must be ignored
        run(8'hF0, N, 5, 300, 1'b1);
        wait_done("fault");
        chk("fault_err_cnt",   err_cnt, 1);
        chk("fault_first_bad", first_bad, 8'h00);

        // restart from DONE with seed 10, valid held high
        run(8'h10, N, -1, -1, 1'b0);
        wait_done("restart");
        chk("restart_rx", rx_cnt, N);

        // narrow counter: every word bad, err_cnt saturates at F
        for (int i = 0; i < NS; i++) begin
            ent.rx   = 16'((i + 1) % 16);
            ent.ec   = (i + 1 > 15) ? 16'hF : 16'(i + 1);
            ent.fb   = 8'hC0;
            ent.e    = 1'b1;
            ent.last = (i == NS - 1);
            exp2_q.push_back(ent);
        end
        pulse_start(1'b1, 8'h40);
        for (int i = 0; i < NS; i++) begin
            send(1'b1, (8'h40 + 8'(i)) ^ 8'h80, 1'b0, ok);
            if (!ok) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_drain", exp2_q.size(), 0);
        chk("sat_done_final", done2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
